// File: rtl/mil_pkg.sv
// Shared definitions for the MIL Manchester-II word receiver:
// timing derivation helpers, line-state encoding and receiver FSM states.
package mil_pkg;

  // Line state as {RXP, RXN} after synchronisation
  typedef enum logic [1:0] {
    LN_Z = 2'b00,
    LN_N = 2'b01,
    LN_P = 2'b10,
    LN_X = 2'b11
  } line_t;

  typedef enum logic [1:0] {
    IDLE,
    SYNC2,
    DATA,
    DONE
  } state_t;

  localparam int unsigned RUN_W = 8;

  // Clocks per bit time
  function automatic int unsigned calc_nb(input int unsigned fclk, input int unsigned rxvel);
    return fclk / rxvel;
  endfunction

  // Clocks per half bit
  function automatic int unsigned calc_nh(input int unsigned nb);
    return nb / 2;
  endfunction

  // Clocks per sync half (1.5 bit times)
  function automatic int unsigned calc_ns(input int unsigned nb);
    return 3 * (nb / 2);
  endfunction

  // Quarter-bit offset placing samples mid-half
  function automatic int unsigned calc_nq(input int unsigned nb);
    return (nb / 2) / 2;
  endfunction

  function automatic logic is_pn(input line_t l);
    return (l == LN_P) || (l == LN_N);
  endfunction

endpackage

// File: rtl/mil_rx_line.sv
// MIL receiver line front end: 2-FF synchroniser, optional 3-sample majority
// glitch filter (MIL_RX_GLITCH_FILT_EN), line-state decode, P<->N transition
// pulse and saturating run-length counter.
module mil_rx_line
  import mil_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             RXP,
  input  logic             RXN,
  output line_t            line,
  output logic             trans,
  output logic [RUN_W-1:0] run
);

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] pn;
  line_t      prev;

  // Two-stage synchroniser for the asynchronous line inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {RXP, RXN};
      sync2 <= sync1;
    end
  end

`ifdef MIL_RX_GLITCH_FILT_EN
  logic [1:0] dly1;
  logic [1:0] dly2;
  logic [1:0] filt;

  // Per-input majority of three consecutive samples, centred on dly1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly1 <= '0;
      dly2 <= '0;
      filt <= '0;
    end else begin
      dly1 <= sync2;
      dly2 <= dly1;
      filt <= (sync2 & dly1) | (sync2 & dly2) | (dly1 & dly2);
    end
  end

  assign pn = filt;
`else
  assign pn = sync2;
`endif

  assign line  = line_t'(pn);
  assign trans = is_pn(line) && is_pn(prev) && (line != prev);

  // run holds the length of the run that ended on the previous cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= LN_Z;
      run  <= '0;
    end else begin
      prev <= line;
      if (!is_pn(line)) begin
        run <= '0;
      end else if (line != prev) begin
        run <= RUN_W'(1);
      end else if (run != '1) begin
        run <= run + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mil_rxd.sv
// MIL (GOST R 52070 / MIL-STD-1553) Manchester-II word receiver.
// Detects the 3-bit-time sync, decodes 16 data bits plus odd parity and
// reports each word with a one-clock rx_ok / rx_perr / rx_merr strobe.
// Optional build macro: MIL_RX_GLITCH_FILT_EN (majority filter in mil_rx_line).
module mil_rxd
  import mil_pkg::*;
#(
  parameter int unsigned Fclk  = 50000000,
  parameter int unsigned RXvel = 1000000,
  parameter int unsigned TOL   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RXP,
  input  logic        RXN,
  output logic [15:0] rx_dat,
  output logic        rx_cw,
  output logic        rx_ok,
  output logic        rx_perr,
  output logic        rx_merr,
  output logic        rx_busy
);

  localparam int unsigned NB = calc_nb(Fclk, RXvel);
  localparam int unsigned NH = calc_nh(NB);
  localparam int unsigned NS = calc_ns(NB);
  localparam int unsigned NQ = calc_nq(NB);
  localparam int unsigned TW = $clog2(NS + 18 * NB);

  localparam logic [RUN_W-1:0] SYNC_MIN   = RUN_W'(NS - TOL);
  localparam logic [TW-1:0]    T_SYNC_END = TW'(NS - TOL);
  localparam logic [TW-1:0]    T_FIRST    = TW'(NS + NQ);
  localparam logic [TW-1:0]    T_AB       = TW'(NH);
  localparam logic [TW-1:0]    T_BA       = TW'(NB - NH);

  line_t            line;
  logic             trans;
  logic [RUN_W-1:0] run;

  state_t      state;
  state_t      state_nxt;
  logic [TW-1:0] ph;
  logic [TW-1:0] tgt;
  logic        half;
  logic [4:0]  bitn;
  logic [15:0] sh;
  logic        par_acc;
  logic        merr_acc;
  line_t       a_smp;
  line_t       sync_st;
  logic        cw_cur;
  logic        ok_f;
  logic        perr_f;
  logic        merr_f;

  logic        sync_hit;
  logic        smp;
  logic        last;
  logic        b_val;
  logic        b_bad;
  logic        merr_fin;
  logic        par_fin;

  mil_rx_line u_line (
    .clk  (clk),
    .rst  (rst),
    .RXP  (RXP),
    .RXN  (RXN),
    .line (line),
    .trans(trans),
    .run  (run)
  );

  assign sync_hit = trans && (run >= SYNC_MIN);
  assign smp      = (state == DATA) && (ph == tgt);
  assign last     = smp && half && (bitn == 5'd16);
  assign merr_fin = merr_acc | b_bad;
  assign par_fin  = par_acc ^ b_val;

  // Decode the current A sample against the line as the B sample
  always_comb begin
    b_val = 1'b0;
    b_bad = 1'b1;
    if ((a_smp == LN_P) && (line == LN_N)) begin
      b_val = 1'b1;
      b_bad = 1'b0;
    end else if ((a_smp == LN_N) && (line == LN_P)) begin
      b_val = 1'b0;
      b_bad = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (sync_hit) state_nxt = SYNC2;
      SYNC2: begin
        if (line != sync_st) begin
          state_nxt = IDLE;
        end else if (ph == T_SYNC_END) begin
          state_nxt = DATA;
        end
      end
      DATA:  if (last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: strobes live only in DONE, busy covers the data field
  always_comb begin
    rx_busy = (state == DATA);
    rx_ok   = (state == DONE) && ok_f;
    rx_perr = (state == DONE) && perr_f;
    rx_merr = (state == DONE) && merr_f;
  end

  // Timing from T, half-bit sampling, shift/parity accumulation, word result.
  // Sample points are kept as a running target (tgt) stepped by half/remaining
  // bit time rather than multiplying out T + NS + NB*k + ... each bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph       <= '0;
      tgt      <= '0;
      half     <= 1'b0;
      bitn     <= '0;
      sh       <= '0;
      par_acc  <= 1'b0;
      merr_acc <= 1'b0;
      a_smp    <= LN_Z;
      sync_st  <= LN_Z;
      cw_cur   <= 1'b0;
      ok_f     <= 1'b0;
      perr_f   <= 1'b0;
      merr_f   <= 1'b0;
      rx_dat   <= '0;
      rx_cw    <= 1'b0;
    end else begin
      if ((state == IDLE) && sync_hit) begin
        ph       <= TW'(1);
        tgt      <= T_FIRST;
        half     <= 1'b0;
        bitn     <= '0;
        par_acc  <= 1'b0;
        merr_acc <= 1'b0;
        sync_st  <= line;
        cw_cur   <= (line == LN_N);
      end else if ((state == SYNC2) || (state == DATA)) begin
        ph <= ph + 1'b1;
      end

      if (smp) begin
        if (!half) begin
          a_smp <= line;
          half  <= 1'b1;
          tgt   <= tgt + T_AB;
        end else begin
          half     <= 1'b0;
          tgt      <= tgt + T_BA;
          bitn     <= bitn + 1'b1;
          par_acc  <= par_fin;
          merr_acc <= merr_fin;
          if (bitn != 5'd16) begin
            sh <= {sh[14:0], b_val};
          end
        end
      end

      if (last) begin
        merr_f <= merr_fin;
        perr_f <= !merr_fin && !par_fin;
        ok_f   <= !merr_fin && par_fin;
        if (!merr_fin && par_fin) begin
          rx_dat <= sh;
          rx_cw  <= cw_cur;
        end
      end
    end
  end

endmodule

// File: tb/tb_mil_rxd.sv
// Self-checking bench for mil_rxd: drives Manchester-II words on RXP/RXN and
// compares strobes, timing and held data against a word-level model.
module tb_mil_rxd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RXP = 1'b0;
  logic        RXN = 1'b0;
  logic [15:0] rx_dat;
  logic        rx_cw;
  logic        rx_ok;
  logic        rx_perr;
  logic        rx_merr;
  logic        rx_busy;

`ifdef MIL_RX_GLITCH_FILT_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int DLY = 913;

  localparam logic [1:0] LP = 2'b10;
  localparam logic [1:0] LN = 2'b01;
  localparam logic [1:0] LZ = 2'b00;
  localparam logic [1:0] LX = 2'b11;

  localparam logic [2:0] K_OK   = 3'b100;
  localparam logic [2:0] K_PERR = 3'b010;
  localparam logic [2:0] K_MERR = 3'b001;

  mil_rxd #(.Fclk(50000000), .RXvel(1000000), .TOL(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .RXP    (RXP),
    .RXN    (RXN),
    .rx_dat (rx_dat),
    .rx_cw  (rx_cw),
    .rx_ok  (rx_ok),
    .rx_perr(rx_perr),
    .rx_merr(rx_merr),
    .rx_busy(rx_busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          c;
    logic [2:0]  k;
    logic [15:0] d;
    logic        cw;
    logic        busy;
  } ev_t;

  ev_t evq[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  logic [15:0] exp_dat = '0;
  logic        exp_cw  = 1'b0;

  // Strobe monitor: records every strobe, checks they never coincide
  always @(negedge clk) begin
    if (!rst && (rx_ok || rx_perr || rx_merr)) begin
      n_chk++;
      if ($countones({rx_ok, rx_perr, rx_merr}) != 1) begin
        n_fail++;
        $display("FAIL strobe_onehot: got %b want exactly one set", {rx_ok, rx_perr, rx_merr});
      end
      evq.push_back('{cyc, {rx_ok, rx_perr, rx_merr}, rx_dat, rx_cw, rx_busy});
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic tx_half(input logic [1:0] v, input int len);
    {RXP, RXN} = v;
    repeat (len) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sync: 1.5 bit of first level, then 1.5 bit of the other; e = cycle of T
  task automatic tx_sync(input bit cw, output int e);
    tx_half(cw ? LP : LN, 75);
    e = cyc;
    tx_half(cw ? LN : LP, 75);
  endtask

  task automatic tx_bit(input logic [1:0] h1, input logic [1:0] h2);
    tx_half(h1, 25);
    tx_half(h2, 25);
  endtask

  // One word on the line; parity is odd unless pbad, mbit>=0 replaces that bit by mcode,mcode
  task automatic send_word(input logic [15:0] d, input bit cw, input bit pbad,
                           input int mbit, input logic [1:0] mcode,
                           input bit idle_after, output int e);
    logic [16:0] bits;
    logic        pbit;
    pbit = (($countones(d) % 2) == 0) ^ pbad;
    bits = {d, pbit};
    tx_sync(cw, e);
    for (int k = 0; k < 17; k++) begin
      if (k == mbit) tx_bit(mcode, mcode);
      else if (bits[16-k]) tx_bit(LP, LN);
      else tx_bit(LN, LP);
    end
    if (idle_after) tx_half(LZ, 30);
  endtask

  task automatic get_evt(output ev_t ev, output bit got);
    got = 1'b0;
    for (int i = 0; i < 1200 && evq.size() == 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (evq.size() > 0) begin
      ev  = evq.pop_front();
      got = 1'b1;
    end
  endtask

  // Word-level reference: merr dominates, else odd popcount of 17 bits is good
  function automatic logic [2:0] exp_kind(input logic [15:0] d, input bit pbad, input int mbit);
    int ones;
    if (mbit >= 0) return K_MERR;
    ones = $countones(d) + ((($countones(d) % 2) == 0) ^ pbad);
    return (ones % 2 == 1) ? K_OK : K_PERR;
  endfunction

  task automatic test_reset;
    tx_half(LZ, 5);
    n_chk++;
    if ({rx_dat, rx_cw, rx_ok, rx_perr, rx_merr, rx_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {rx_dat, rx_cw, rx_ok, rx_perr, rx_merr, rx_busy});
    end
    rst = 1'b0;
    tx_half(LZ, 200);
    n_chk++;
    if ({rx_dat, rx_cw, rx_busy} !== '0 || evq.size() != 0) begin
      n_fail++;
      $display("FAIL idle_after_reset: outs %h events %0d want 0", {rx_dat, rx_cw, rx_busy}, evq.size());
    end
  endtask

  task automatic test_cmd_word;
    int e; ev_t ev; bit got;
    send_word(16'hA5C3, 1'b1, 1'b0, -1, LZ, 1'b1, e);
    get_evt(ev, got);
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL cmd_present: no strobe, want rx_ok"); end
    else begin
      n_chk++; if (ev.k !== K_OK) begin n_fail++; $display("FAIL cmd_kind: got %b want %b", ev.k, K_OK); end
      n_chk++; if (ev.c !== e + LAT + DLY) begin n_fail++; $display("FAIL cmd_time: got %0d want %0d", ev.c, e + LAT + DLY); end
      n_chk++; if (ev.d !== 16'hA5C3) begin n_fail++; $display("FAIL cmd_dat: got %h want a5c3", ev.d); end
      n_chk++; if (ev.cw !== 1'b1) begin n_fail++; $display("FAIL cmd_cw: got %b want 1", ev.cw); end
      n_chk++; if (ev.busy !== 1'b0) begin n_fail++; $display("FAIL cmd_busy_strobe: got %b want 0", ev.busy); end
    end
    exp_dat = 16'hA5C3; exp_cw = 1'b1;
  endtask

  task automatic test_data_zero;
    int e; ev_t ev; bit got;
    send_word(16'h0000, 1'b0, 1'b0, -1, LZ, 1'b1, e);
    get_evt(ev, got);
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL zero_present: no strobe, want rx_ok"); end
    else begin
      n_chk++; if (ev.k !== K_OK) begin n_fail++; $display("FAIL zero_kind: got %b want %b", ev.k, K_OK); end
      n_chk++; if (ev.d !== 16'h0000 || ev.cw !== 1'b0) begin n_fail++; $display("FAIL zero_dat: got %h/%b want 0000/0", ev.d, ev.cw); end
    end
    exp_dat = 16'h0000; exp_cw = 1'b0;
  endtask

  task automatic test_parity_err;
    int e; ev_t ev; bit got;
    send_word(16'hA5C3, 1'b1, 1'b1, -1, LZ, 1'b1, e);
    get_evt(ev, got);
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL perr_present: no strobe, want rx_perr"); end
    else begin
      n_chk++; if (ev.k !== K_PERR) begin n_fail++; $display("FAIL perr_kind: got %b want %b", ev.k, K_PERR); end
      n_chk++; if (ev.d !== exp_dat || ev.cw !== exp_cw) begin n_fail++; $display("FAIL perr_hold: got %h/%b want %h/%b", ev.d, ev.cw, exp_dat, exp_cw); end
    end
  endtask

  task automatic test_manchester;
    int e; ev_t ev; bit got;
    send_word(16'hFFFF, 1'b1, 1'b0, 5, LP, 1'b1, e);
    get_evt(ev, got);
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL merr_present: no strobe, want rx_merr"); end
    else begin
      n_chk++; if (ev.k !== K_MERR) begin n_fail++; $display("FAIL merr_kind: got %b want %b", ev.k, K_MERR); end
      n_chk++; if (ev.c !== e + LAT + DLY) begin n_fail++; $display("FAIL merr_time: got %0d want %0d", ev.c, e + LAT + DLY); end
      n_chk++; if (ev.d !== exp_dat || ev.cw !== exp_cw) begin n_fail++; $display("FAIL merr_hold: got %h/%b want %h/%b", ev.d, ev.cw, exp_dat, exp_cw); end
    end
  endtask

  task automatic test_back_to_back;
    int e1, e2; ev_t ev1, ev2; bit g1, g2;
    send_word(16'h1234, 1'b1, 1'b0, -1, LZ, 1'b0, e1);
    send_word(16'hBEEF, 1'b0, 1'b0, -1, LZ, 1'b1, e2);
    get_evt(ev1, g1);
    get_evt(ev2, g2);
    n_chk++;
    if (!g1 || !g2) begin n_fail++; $display("FAIL b2b_present: got %0d%0d want 11", g1, g2); end
    else begin
      n_chk++; if (ev1.k !== K_OK || ev2.k !== K_OK) begin n_fail++; $display("FAIL b2b_kind: got %b %b want %b", ev1.k, ev2.k, K_OK); end
      n_chk++; if (ev1.c !== e1 + LAT + DLY) begin n_fail++; $display("FAIL b2b_time1: got %0d want %0d", ev1.c, e1 + LAT + DLY); end
      n_chk++; if (ev2.c - ev1.c !== 1000) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 1000", ev2.c - ev1.c); end
      n_chk++; if (ev1.d !== 16'h1234 || ev1.cw !== 1'b1) begin n_fail++; $display("FAIL b2b_w1: got %h/%b want 1234/1", ev1.d, ev1.cw); end
      n_chk++; if (ev2.d !== 16'hBEEF || ev2.cw !== 1'b0) begin n_fail++; $display("FAIL b2b_w2: got %h/%b want beef/0", ev2.d, ev2.cw); end
    end
    exp_dat = 16'hBEEF; exp_cw = 1'b0;
  endtask

  task automatic test_random;
    int e, sel, mbit; bit pbad, cw, got; logic [15:0] d; logic [1:0] mcode; logic [2:0] k; ev_t ev;
    for (int i = 0; i < 12; i++) begin
      d = 16'($urandom);
      cw = 1'($urandom);
      sel = int'($urandom_range(0, 3));
      pbad = (sel == 2);
      mbit = (sel == 3) ? int'($urandom_range(0, 16)) : -1;
      case ($urandom_range(0, 3))
        0: mcode = LP;
        1: mcode = LN;
        2: mcode = LZ;
        default: mcode = LX;
      endcase
      k = exp_kind(d, pbad, mbit);
      send_word(d, cw, pbad, mbit, mcode, 1'b0, e);
      tx_half(LZ, int'($urandom_range(30, 120)));
      if (k == K_OK) begin exp_dat = d; exp_cw = cw; end
      get_evt(ev, got);
      n_chk++;
      if (!got) begin n_fail++; $display("FAIL rnd%0d_present: no strobe for %h", i, d); end
      else begin
        n_chk++; if (ev.k !== k) begin n_fail++; $display("FAIL rnd%0d_kind: got %b want %b (d=%h mbit=%0d)", i, ev.k, k, d, mbit); end
        n_chk++; if (ev.c !== e + LAT + DLY) begin n_fail++; $display("FAIL rnd%0d_time: got %0d want %0d", i, ev.c, e + LAT + DLY); end
        n_chk++; if (ev.d !== exp_dat || ev.cw !== exp_cw) begin n_fail++; $display("FAIL rnd%0d_dat: got %h/%b want %h/%b", i, ev.d, ev.cw, exp_dat, exp_cw); end
      end
    end
  endtask

  task automatic test_reset_midword;
    int e; ev_t ev; bit got; logic [16:0] bits;
    send_word(16'h0F0F, 1'b1, 1'b0, -1, LZ, 1'b1, e);
    get_evt(ev, got);
    n_chk++;
    if (!got || ev.k !== K_OK || ev.d !== 16'h0F0F) begin n_fail++; $display("FAIL pre_rst_word: got %0d/%b/%h want 1/%b/0f0f", got, ev.k, ev.d, K_OK); end
    bits = {16'h3C3C, 1'b1};
    tx_sync(1'b0, e);
    for (int k = 0; k < 8; k++) begin
      if (bits[16-k]) tx_bit(LP, LN);
      else tx_bit(LN, LP);
    end
    n_chk++;
    if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL busy_midword: got %b want 1", rx_busy); end
    rst = 1'b1;
    #2;
    n_chk++;
    if ({rx_dat, rx_cw, rx_ok, rx_perr, rx_merr, rx_busy} !== '0) begin
      n_fail++;
      $display("FAIL rst_midword_outs: got %h want 0", {rx_dat, rx_cw, rx_ok, rx_perr, rx_merr, rx_busy});
    end
    {RXP, RXN} = LZ;
    @(posedge clk);
    #1;
    tx_half(LZ, 3);
    rst = 1'b0;
    tx_half(LZ, 1100);
    n_chk++;
    if (evq.size() != 0) begin n_fail++; $display("FAIL rst_no_strobe: got %0d events want 0", evq.size()); end
    send_word(16'h5555, 1'b0, 1'b0, -1, LZ, 1'b1, e);
    get_evt(ev, got);
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL post_rst_present: no strobe, want rx_ok"); end
    else begin
      n_chk++; if (ev.k !== K_OK) begin n_fail++; $display("FAIL post_rst_kind: got %b want %b", ev.k, K_OK); end
      n_chk++; if (ev.d !== 16'h5555 || ev.cw !== 1'b0) begin n_fail++; $display("FAIL post_rst_dat: got %h/%b want 5555/0", ev.d, ev.cw); end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_cmd_word();
    test_data_zero();
    test_parity_err();
    test_manchester();
    test_back_to_back();
    test_random();
    test_reset_midword();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
